fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter sharing the single write port of the team's synchronous FIFO (syncfifo) between N producers.
- Grants at most one requester per cycle and drives the FIFO write enable and write data.
- Honours FIFO full; optionally locks a grant for a bounded burst.
- Sits directly in front of syncfifo; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
// Optional grant statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

    localparam int DEF_N         = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_PW        = idx_w(DEF_N);
    localparam int DEF_CNTW      = cnt_w(DEF_BURST_LEN);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer requests, FIFO write port and status between producers and the arbiter.
// Handshake: req[k] is a level held (with wdata slice k stable) until gnt[k]; a word moves in any cycle where req[k] & gnt[k].
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 16
);
    localparam int PW = idx_w(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           fifo_full;
    logic           fifo_write_en;
    logic [W-1:0]   fifo_data_in;
    logic [PW-1:0]  owner;
    logic           locked;
    logic [PW-1:0]  stat_sel;
    logic [CW-1:0]  stat_cnt;
    arb_state_t     dbg_state;

    modport master (
        output req, wdata, fifo_full, stat_sel,
        input  gnt, fifo_write_en, fifo_data_in, owner, locked, stat_cnt, dbg_state
    );

    modport slave (
        input  req, wdata, fifo_full, stat_sel,
        output gnt, fifo_write_en, fifo_data_in, owner, locked, stat_cnt, dbg_state
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping N-1 -> 0.
// Purely combinational so it can be reused by other schedulers.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the syncfifo write port between N producers, with optional burst lock.
// Define FIFO_ARB_STATS_EN to add per-requester saturating grant counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int BURST_LEN = 4,
    parameter int CW        = 16
) (
    input  logic              clk,
    input  logic              reset,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int PW   = idx_w(N);
    localparam int CNTW = cnt_w(BURST_LEN);
    localparam logic [CNTW-1:0] BURST_MAX = CNTW'(BURST_LEN);

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [N-1:0]    gnt;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   pick_ptr;
    logic [N-1:0]    pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(N - 1)) ? '0 : PW'(i + 1'b1);
    endfunction

    // A lock whose owner has gone idle hands priority to the owner's successor.
    assign pick_ptr = (state_q == LOCK) ? next_idx(owner_q) : ptr_q;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        gidx    = '0;
        // A full FIFO freezes everything, including a lock whose owner went idle.
        if (!reset && !bus.fifo_full) begin
            if (state_q == LOCK && bus.req[owner_q]) begin
                gnt[owner_q] = 1'b1;
                gidx         = owner_q;
                cnt_d        = CNTW'(cnt_q + 1'b1);
                if (CNTW'(cnt_q + 1'b1) == BURST_MAX) begin
                    state_d = ARB;
                    cnt_d   = '0;
                    ptr_d   = next_idx(owner_q);
                end
            end else begin
                if (state_q == LOCK) begin
                    state_d = ARB;
                    cnt_d   = '0;
                    ptr_d   = next_idx(owner_q);
                end
                if (pick_any) begin
                    gnt  = pick_gnt;
                    gidx = pick_idx;
                    if (BURST_LEN > 1) begin
                        state_d = LOCK;
                        owner_d = pick_idx;
                        cnt_d   = CNTW'(1);
                    end else begin
                        ptr_d = next_idx(pick_idx);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.fifo_data_in = '0;
        if (|gnt) bus.fifo_data_in = bus.wdata[int'(gidx)*W +: W];
    end

    assign bus.gnt           = gnt;
    assign bus.fifo_write_en = |gnt;
    assign bus.owner         = owner_q;
    assign bus.locked        = (state_q == LOCK);
    assign bus.dbg_state     = state_q;

`ifdef FIFO_ARB_STATS_EN
    logic [CW-1:0] stat_q [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) stat_q[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (gnt[k] && (stat_q[k] != {CW{1'b1}})) stat_q[k] <= stat_q[k] + 1'b1;
            end
        end
    end

    // Selects beyond N-1 (non-power-of-2 N) read as zero.
    always_comb begin
        bus.stat_cnt = '0;
        if (int'(bus.stat_sel) < N) bus.stat_cnt = stat_q[bus.stat_sel];
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^bus.stat_sel;
    assign bus.stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-beat round-robin instance (a) and burst-lock instance (b).
// Statistics checks follow FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .W(W), .CW(16)) ifa ();
    fifo_wr_arbiter_if #(.N(N), .W(W), .CW(4))  ifb ();

    fifo_wr_arbiter #(.N(N), .W(W), .BURST_LEN(1), .CW(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    fifo_wr_arbiter #(.N(N), .W(W), .BURST_LEN(4), .CW(4)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifa.req = '0;
        ifb.req = '0;
        ifa.fifo_full = 1'b0;
        ifb.fifo_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifa.req = 4'hF;
        ifb.req = 4'hF;
        #1;
        checks++;
        if (ifa.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt_a: got %b expected 0000", ifa.gnt); end
        checks++;
        if (ifb.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt_b: got %b expected 0000", ifb.gnt); end
        checks++;
        if (ifb.fifo_write_en !== 1'b0) begin errors++; $display("FAIL reset_wen_b: got %b expected 0", ifb.fifo_write_en); end
        checks++;
        if (ifa.fifo_data_in !== 8'h00) begin errors++; $display("FAIL reset_data_a: got %h expected 00", ifa.fifo_data_in); end
        tick();
        tick();
        checks++;
        if (ifb.locked !== 1'b0) begin errors++; $display("FAIL reset_locked_b: got %b expected 0", ifb.locked); end
        checks++;
        if (ifb.owner !== 2'd0) begin errors++; $display("FAIL reset_owner_b: got %0d expected 0", ifb.owner); end
        ifa.req = '0;
        ifb.req = '0;
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({ifb.gnt, ifb.fifo_write_en, ifb.fifo_data_in, ifb.locked} !== '0) begin
                errors++;
                $display("FAIL idle_outputs: got gnt=%b wen=%b data=%h locked=%b expected all 0",
                         ifb.gnt, ifb.fifo_write_en, ifb.fifo_data_in, ifb.locked);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] exp_d;
        do_reset();
        ifa.req = 4'hF;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + W'(i % 4));
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_d = exp_q.pop_front();
            checks++;
            if (ifa.gnt !== exp_gnt[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, ifa.gnt, exp_gnt[i]); end
            checks++;
            if (ifa.fifo_data_in !== exp_d) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, ifa.fifo_data_in, exp_d); end
            checks++;
            if (ifa.locked !== 1'b0) begin errors++; $display("FAIL rr_locked[%0d]: got %b expected 0", i, ifa.locked); end
            tick();
        end
        ifa.req = '0;
    endtask

    task automatic test_burst();
        logic [3:0] exp_gnt [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        logic       exp_lk  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        ifb.req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (ifb.gnt !== exp_gnt[i]) begin errors++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, ifb.gnt, exp_gnt[i]); end
            checks++;
            if (ifb.locked !== exp_lk[i]) begin errors++; $display("FAIL burst_locked[%0d]: got %b expected %b", i, ifb.locked, exp_lk[i]); end
            if (i == 6) begin
                checks++;
                if (ifb.owner !== 2'd1) begin errors++; $display("FAIL burst_owner: got %0d expected 1", ifb.owner); end
                checks++;
                if (ifb.dbg_state !== LOCK) begin errors++; $display("FAIL burst_state: got %0d expected %0d", ifb.dbg_state, LOCK); end
            end
            tick();
        end
        ifb.req = '0;
    endtask

    task automatic test_full_stall();
        logic [3:0] exp_after [3] = '{4'b0001, 4'b0001, 4'b0010};
        do_reset();
        ifb.req = 4'b0011;
        tick();
        tick();
        ifb.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ifb.gnt !== 4'b0000 || ifb.fifo_write_en !== 1'b0) begin
                errors++; $display("FAIL stall_gnt[%0d]: got gnt=%b wen=%b expected 0000/0", i, ifb.gnt, ifb.fifo_write_en);
            end
            checks++;
            if (ifb.locked !== 1'b1 || ifb.owner !== 2'd0) begin
                errors++; $display("FAIL stall_lock[%0d]: got locked=%b owner=%0d expected 1/0", i, ifb.locked, ifb.owner);
            end
            tick();
        end
        ifb.fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ifb.gnt !== exp_after[i]) begin errors++; $display("FAIL stall_resume[%0d]: got %b expected %b", i, ifb.gnt, exp_after[i]); end
            tick();
        end
        ifb.req = '0;
    endtask

    task automatic test_owner_drop();
        do_reset();
        ifb.req = 4'b0101;
        #1;
        checks++;
        if (ifb.gnt !== 4'b0001) begin errors++; $display("FAIL drop_first: got %b expected 0001", ifb.gnt); end
        tick();
        ifb.req = 4'b0100;
        #1;
        checks++;
        if (ifb.gnt !== 4'b0100) begin errors++; $display("FAIL drop_gnt: got %b expected 0100", ifb.gnt); end
        checks++;
        if (ifb.fifo_data_in !== 8'hB2) begin errors++; $display("FAIL drop_data: got %h expected b2", ifb.fifo_data_in); end
        tick();
        checks++;
        if (ifb.owner !== 2'd2 || ifb.locked !== 1'b1) begin
            errors++; $display("FAIL drop_owner: got owner=%0d locked=%b expected 2/1", ifb.owner, ifb.locked);
        end
        checks++;
        if (ifb.gnt !== 4'b0100) begin errors++; $display("FAIL drop_beat2: got %b expected 0100", ifb.gnt); end
        ifb.req = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ifb.req = 4'b0011;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ifb.gnt !== 4'b0000 || ifb.fifo_write_en !== 1'b0) begin
            errors++; $display("FAIL midrst_gnt: got gnt=%b wen=%b expected 0000/0", ifb.gnt, ifb.fifo_write_en);
        end
        tick();
        checks++;
        if (ifb.locked !== 1'b0 || ifb.gnt !== 4'b0000) begin
            errors++; $display("FAIL midrst_locked: got locked=%b gnt=%b expected 0/0000", ifb.locked, ifb.gnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ifb.gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first: got %b expected 0001", ifb.gnt); end
        tick();
        ifb.req = '0;
    endtask

    task automatic test_stats();
        logic [3:0] exp_cnt;
        do_reset();
`ifdef FIFO_ARB_STATS_EN
        ifb.req = 4'b1000;
        for (int i = 0; i < 20; i++) tick();
        ifb.req = '0;
        for (int s = 0; s < 4; s++) begin
            ifb.stat_sel = 2'(s);
            exp_cnt = (s == 3) ? 4'd15 : 4'd0;
            #1;
            checks++;
            if (ifb.stat_cnt !== exp_cnt) begin errors++; $display("FAIL stat_cnt[%0d]: got %0d expected %0d", s, ifb.stat_cnt, exp_cnt); end
        end
`else
        ifb.req = 4'b1000;
        ifa.req = 4'hF;
        for (int i = 0; i < 5; i++) tick();
        ifb.req = '0;
        ifa.req = '0;
        exp_cnt = 4'd0;
        for (int s = 0; s < 4; s++) begin
            ifb.stat_sel = 2'(s);
            ifa.stat_sel = 2'(s);
            #1;
            checks++;
            if (ifb.stat_cnt !== exp_cnt || ifa.stat_cnt !== 16'd0) begin
                errors++; $display("FAIL stat_tied[%0d]: got %0d/%0d expected 0/0", s, ifa.stat_cnt, ifb.stat_cnt);
            end
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        ifa.req = '0;
        ifb.req = '0;
        ifa.fifo_full = 1'b0;
        ifb.fifo_full = 1'b0;
        ifa.stat_sel = '0;
        ifb.stat_sel = '0;
        ifa.wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ifb.wdata = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        tick();

        test_reset();
        test_idle();
        test_round_robin();
        test_burst();
        test_full_stall();
        test_owner_drop();
        test_reset_mid_burst();
        test_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
